clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_meter_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clock_period_meter.sv | 143 ++++++++++++++
 tb/tb_clock_period_meter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_meter_pkg;

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } meter_state_t;

    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_LOCK_COUNT     = 4;
    localparam int DEF_TOLERANCE      = 1;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by an edge register; rise is high one cycle
// per synchronized rising edge of async_in.
module sync_edge_detect
    import clock_meter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= async_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign sync_out = r_sync;
    assign rise     = r_sync & ~r_sync_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of clk_in in clk cycles and reports lock/timeout status.
// Define CLOCK_PERIOD_METER_DUTY_EN to add the high_time output.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int TOLERANCE      = DEF_TOLERANCE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    ,
    output logic [CNT_WIDTH-1:0] high_time
`endif
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TO_C   = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TOL_C  = CNT_WIDTH'(TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] MAX_C  = '1;
    localparam logic [MW-1:0]        ONE_M  = MW'(1);
    localparam logic [MW-1:0]        LOCK_M = MW'(LOCK_COUNT);

    logic w_sync;
    logic w_rise;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (clk_in),
        .sync_out (w_sync),
        .rise     (w_rise)
    );

    meter_state_t         r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_prev;
    logic                 r_have_prev;
    logic                 r_period_valid;
    logic                 r_locked;
    logic                 r_timeout;
    logic [MW-1:0]        r_match;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic [CNT_WIDTH-1:0] r_high_cnt;
    logic [CNT_WIDTH-1:0] r_high_time;
    assign high_time = r_high_time;
`else
    logic w_unused_sync;
    assign w_unused_sync = w_sync;
`endif

    logic [CNT_WIDTH-1:0] w_diff;
    logic                 w_match_ok;
    logic [MW-1:0]        w_match_next;
    logic                 w_counting;
    logic                 w_to_fire;

    // A measurement only matches when a previous period from the same run exists.
    assign w_diff       = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
    assign w_match_ok   = r_have_prev && (w_diff <= TOL_C);
    assign w_match_next = !w_match_ok        ? '0 :
                          (r_match == LOCK_M) ? LOCK_M : (r_match + ONE_M);

    // While timed out, the counter keeps running in WAIT_EDGE so the flag is re-armed.
    assign w_counting = (r_state == MEASURE) || r_timeout;
    assign w_to_fire  = !w_rise && w_counting && (r_cnt == TO_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= WAIT_EDGE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_prev         <= '0;
            r_have_prev    <= 1'b0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_match        <= '0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
            r_high_cnt     <= '0;
            r_high_time    <= '0;
`endif
        end else begin
            r_period_valid <= 1'b0;
            if (w_rise) begin
                r_state   <= MEASURE;
                r_cnt     <= ONE_C;
                r_timeout <= 1'b0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                r_high_cnt <= ONE_C;
`endif
                if (r_state == MEASURE) begin
                    r_period       <= r_cnt;
                    r_period_valid <= 1'b1;
                    r_prev         <= r_cnt;
                    r_have_prev    <= 1'b1;
                    r_match        <= w_match_next;
                    r_locked       <= (w_match_next == LOCK_M);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                    r_high_time    <= r_high_cnt;
`endif
                end
            end else if (w_to_fire) begin
                r_state     <= WAIT_EDGE;
                r_cnt       <= ONE_C;
                r_timeout   <= 1'b1;
                r_period    <= '0;
                r_locked    <= 1'b0;
                r_match     <= '0;
                r_have_prev <= 1'b0;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                r_high_time <= '0;
`endif
            end else if (w_counting) begin
                if (r_cnt != MAX_C) begin
                    r_cnt <= r_cnt + ONE_C;
                end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
                if (w_sync && (r_high_cnt != MAX_C)) begin
                    r_high_cnt <= r_high_cnt + ONE_C;
                end
`endif
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter (timeout shortened to 100 cycles).
module tb_clock_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_in;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        timeout;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic [15:0] high_time;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned per;
        bit          lk;
        int unsigned hi;
    } meas_t;

    meas_t exp_q[$];
    meas_t obs_q[$];

    clock_period_meter #(
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (100),
        .LOCK_COUNT     (4),
        .TOLERANCE      (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_in       (clk_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        ,
        .high_time    (high_time)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        meas_t m;
        if (period_valid === 1'b1) begin
            m.per = period;
            m.lk  = locked;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
            m.hi  = high_time;
`else
            m.hi  = 0;
`endif
            obs_q.push_back(m);
        end
    end

    task automatic do_reset();
        reset  = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drive_period(input int hi, input int lo, input bit exp_lk);
        meas_t m;
        m.per = hi + lo;
        m.lk  = exp_lk;
        m.hi  = hi;
        exp_q.push_back(m);
        clk_in = 1'b1;
        repeat (hi) @(negedge clk);
        clk_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic close_measure();
        clk_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        clk_in = 1'b0;
        #2;
        checks++;
        if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++;
        if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", period_valid); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_lock();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 6; k++) drive_period(10, 10, k >= 4);
        close_measure();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL lock_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.lk !== e.lk) begin
                errors++; $display("FAIL lock_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
            end
        end
    endtask

    task automatic test_timeout();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 6; k++) drive_period(10, 10, k >= 4);
        clk_in = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            @(negedge clk);
            if (k == 10) clk_in = 1'b0;
            if (k == 102) begin
                checks++;
                if (timeout !== 1'b0 || locked !== 1'b1 || period !== 16'd20) begin
                    errors++; $display("FAIL timeout_early: timeout=%b locked=%b period=%0d want 0/1/20", timeout, locked, period);
                end
            end
            if (k == 103) begin
                checks++;
                if (timeout !== 1'b1 || locked !== 1'b0 || period !== 16'd0) begin
                    errors++; $display("FAIL timeout_fire: timeout=%b locked=%b period=%0d want 1/0/0", timeout, locked, period);
                end
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL timeout_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.lk !== e.lk) begin
                errors++; $display("FAIL timeout_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
            end
        end
        obs_q.delete();
        clk_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b want 1", timeout); end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout); end
        repeat (5) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_first_edge: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_step();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 6; k++) drive_period(10, 10, k >= 4);
        for (int k = 0; k < 5; k++) drive_period(15, 15, k == 4);
        close_measure();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL step_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.lk !== e.lk) begin
                errors++; $display("FAIL step_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
            end
        end
    endtask

    task automatic test_tolerance();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 10; k++) drive_period(10, (k % 2 == 0) ? 10 : 11, k >= 4);
        close_measure();
        do begin
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL tol_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o.per !== e.per || o.lk !== e.lk) begin
                    errors++; $display("FAIL tol_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
                end
            end
        end while (0);
        do_reset();
        for (int k = 0; k < 8; k++) drive_period(10, (k % 2 == 0) ? 10 : 12, 1'b0);
        close_measure();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL tol2_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.lk !== e.lk) begin
                errors++; $display("FAIL tol2_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
            end
        end
    endtask

    task automatic test_reset_mid();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 6; k++) drive_period(10, 10, k >= 4);
        clk_in = 1'b1;
        repeat (10) @(negedge clk);
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (period !== 16'd20 || locked !== 1'b1) begin
            errors++; $display("FAIL rmid_before: period=%0d locked=%b want 20/1", period, locked);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (period !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL rmid_async: period=%0d valid=%b locked=%b timeout=%b want all 0", period, period_valid, locked, timeout);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        drive_period(10, 10, 1'b0);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_first_rise: got %0d pulses want 0", obs_q.size()); end
        drive_period(10, 10, 1'b0);
        close_measure();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rmid_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.lk !== e.lk) begin
                errors++; $display("FAIL rmid_meas: period=%0d locked=%0b want period=%0d locked=%0b", o.per, o.lk, e.per, e.lk);
            end
        end
    endtask

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    task automatic test_duty();
        meas_t e, o;
        do_reset();
        for (int k = 0; k < 4; k++) drive_period(6, 14, 1'b0);
        close_measure();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL duty_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.per !== e.per || o.hi !== e.hi) begin
                errors++; $display("FAIL duty_meas: period=%0d high=%0d want period=%0d high=%0d", o.per, o.hi, e.per, e.hi);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_step();
        test_tolerance();
        test_reset_mid();
`ifdef CLOCK_PERIOD_METER_DUTY_EN
        test_duty();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
